// File: rtl/pio_event_sequencer.sv
// Avalon-MM master servicing one edge-capture PIO: programs irq_mask, reads and clears
// edge_capture on irq, samples the input level and queues {edges, level} event records.
module pio_event_sequencer #(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] MASK_INIT = {WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_enable,
  input  logic                         i_mask_load,
  input  logic [WIDTH-1:0]             i_mask_value,
  output logic [1:0]                   o_pio_address,
  output logic                         o_pio_chipselect,
  output logic                         o_pio_write_n,
  output logic [WIDTH-1:0]             o_pio_writedata,
  input  logic [WIDTH-1:0]             i_pio_readdata,
  input  logic                         i_pio_irq,
  output logic                         o_evt_valid,
  input  logic                         i_evt_ready,
  output logic [WIDTH-1:0]             o_evt_edges,
  output logic [WIDTH-1:0]             o_evt_level,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
  output logic                         o_overflow,
  input  logic                         i_overflow_clr,
  output logic                         o_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    StInit, StWrMask, StIdle, StRdCap, StClr, StRdLvl, StLvlData
  } state_e;

  state_e           r_state, w_state_next;
  logic             r_mask_pend, w_mask_pend_next;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  logic             r_cs, w_cs;
  logic             r_wn, w_wn;
  logic [1:0]       r_addr, w_addr;
  logic [WIDTH-1:0] r_wdata, w_wdata;

  // Bus outputs are decoded from the next state so they change on the entering edge.
  always_comb begin
    w_state_next     = r_state;
    w_cs             = 1'b0;
    w_wn             = 1'b1;
    w_addr           = 2'd0;
    w_wdata          = '0;
    w_mask_pend_next = r_mask_pend | i_mask_load;

    unique case (r_state)
      StInit:    w_state_next = StWrMask;
      StWrMask:  w_state_next = StIdle;
      StIdle: begin
        if (r_mask_pend) begin
          w_state_next = StWrMask;
        end else if (i_enable && i_pio_irq) begin
          w_state_next = StRdCap;
        end
      end
      StRdCap:   w_state_next = StClr;
      StClr:     w_state_next = StRdLvl;
      StRdLvl:   w_state_next = StLvlData;
      StLvlData: w_state_next = StIdle;
      default:   w_state_next = StInit;
    endcase

    unique case (w_state_next)
      StWrMask: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = 2'd2;
        if (r_state == StInit) begin
          w_wdata = MASK_INIT;
        end else begin
          w_wdata = i_mask_load ? i_mask_value : r_mask;
        end
      end
      StRdCap: begin
        w_cs   = 1'b1;
        w_addr = 2'd3;
      end
      StClr: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = 2'd3;
        w_wdata = '1;
      end
      StRdLvl: begin
        w_cs   = 1'b1;
        w_addr = 2'd0;
      end
      default: ;
    endcase

    // The reset-time MASK_INIT write must not swallow a mask loaded during StInit.
    if (r_state == StIdle && w_state_next == StWrMask) begin
      w_mask_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StInit;
      r_mask_pend <= 1'b0;
      r_mask      <= MASK_INIT;
      r_edge      <= '0;
      r_cs        <= 1'b0;
      r_wn        <= 1'b1;
      r_addr      <= 2'd0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mask_pend <= w_mask_pend_next;
      if (i_mask_load) begin
        r_mask <= i_mask_value;
      end
      if (r_state == StClr) begin
        r_edge <= i_pio_readdata;
      end
      r_cs    <= w_cs;
      r_wn    <= w_wn;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  // Event FIFO, first-word fall-through.
  logic [WIDTH-1:0] r_fifo_edges [FIFO_DEPTH];
  logic [WIDTH-1:0] r_fifo_level [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             w_push, w_pop, w_full, w_push_ok, w_drop;

  always_comb begin
    w_push    = (r_state == StLvlData) && (r_edge != '0);
    w_full    = (r_count == CW'(FIFO_DEPTH));
    w_pop     = (r_count != '0) && i_evt_ready;
    w_push_ok = w_push && (!w_full || w_pop);
    w_drop    = w_push && !w_push_ok;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_edges[r_wr_ptr] <= r_edge;
      r_fifo_level[r_wr_ptr] <= i_pio_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_pio_address    = r_addr;
  assign o_pio_chipselect = r_cs;
  assign o_pio_write_n    = r_wn;
  assign o_pio_writedata  = r_wdata;
  assign o_evt_valid      = (r_count != '0);
  assign o_evt_edges      = r_fifo_edges[r_rd_ptr];
  assign o_evt_level      = r_fifo_level[r_rd_ptr];
  assign o_fifo_count     = r_count;
  assign o_overflow       = r_overflow;
  assign o_busy           = (r_state != StIdle);

endmodule

// File: tb/tb_pio_event_sequencer.sv
// Bench for pio_event_sequencer: behavioural PIO slave plus an event-queue model checked
// every cycle, and directed scenarios with hand-computed bus and FIFO expectations.
module tb_pio_event_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable, mask_load, evt_ready, overflow_clr;
  logic [31:0] mask_value;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n, pio_irq;
  logic [31:0] pio_writedata, pio_rd;
  logic        evt_valid, overflow, busy;
  logic [31:0] evt_edges, evt_level;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  pio_event_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_enable         (enable),
    .i_mask_load      (mask_load),
    .i_mask_value     (mask_value),
    .o_pio_address    (pio_address),
    .o_pio_chipselect (pio_chipselect),
    .o_pio_write_n    (pio_write_n),
    .o_pio_writedata  (pio_writedata),
    .i_pio_readdata   (pio_rd),
    .i_pio_irq        (pio_irq),
    .o_evt_valid      (evt_valid),
    .i_evt_ready      (evt_ready),
    .o_evt_edges      (evt_edges),
    .o_evt_level      (evt_level),
    .o_fifo_count     (fifo_count),
    .o_overflow       (overflow),
    .i_overflow_clr   (overflow_clr),
    .o_busy           (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string name, input logic cs, input logic wn,
                           input logic [1:0] addr, input logic [31:0] wdata);
    check({name, "_cs"}, pio_chipselect, cs);
    check({name, "_wn"}, pio_write_n, wn);
    if (cs) begin
      check({name, "_addr"}, pio_address, addr);
      if (!wn) check({name, "_wdata"}, pio_writedata, wdata);
    end
  endtask

  // PIO slave: falling-edge capture, write-1-to-clear edge_capture, registered readdata.
  logic [31:0] in_port = '0;
  logic [31:0] in_prev, pio_ec, pio_mask;
  logic        irq_force = 1'b0;
  logic        cap_valid, lvl_valid;
  int          mask_writes;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_prev     <= '0;
      pio_ec      <= '0;
      pio_mask    <= '0;
      pio_rd      <= '0;
      cap_valid   <= 1'b0;
      lvl_valid   <= 1'b0;
      mask_writes <= 0;
    end else begin
      in_prev <= in_port;
      pio_ec  <= ((pio_chipselect && !pio_write_n && pio_address == 2'd3) ?
                  (pio_ec & ~pio_writedata) : pio_ec) | (in_prev & ~in_port);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) begin
        pio_mask    <= pio_writedata;
        mask_writes <= mask_writes + 1;
      end
      cap_valid <= pio_chipselect && pio_write_n && pio_address == 2'd3;
      lvl_valid <= pio_chipselect && pio_write_n && pio_address == 2'd0;
      if (pio_chipselect && pio_write_n) begin
        pio_rd <= (pio_address == 2'd0) ? in_port :
                  (pio_address == 2'd3) ? pio_ec :
                  (pio_address == 2'd2) ? pio_mask : 32'h0;
      end
    end
  end

  assign pio_irq = (|(pio_ec & pio_mask)) | irq_force;

  // Event model: each completed edge/level read pair yields one record if edges are nonzero.
  typedef struct packed {
    logic [31:0] e;
    logic [31:0] l;
  } evt_t;

  evt_t        m_q[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cap = '0;

  always @(negedge clk) begin : model
    bit   pop, push, full;
    evt_t rec;
    if (!reset_n) begin
      m_q.delete();
      m_ovf <= 1'b0;
      m_cap <= '0;
    end else begin
      check("cmp_valid", evt_valid, (m_q.size() != 0));
      check("cmp_count", 32'(fifo_count), 32'(m_q.size()));
      check("cmp_overflow", overflow, m_ovf);
      if (m_q.size() != 0) begin
        check("cmp_edges", evt_edges, m_q[0].e);
        check("cmp_level", evt_level, m_q[0].l);
      end
      pop  = (m_q.size() != 0) && evt_ready;
      push = lvl_valid && (m_cap != '0);
      full = (m_q.size() >= DEPTH);
      if (pop) void'(m_q.pop_front());
      if (push && (!full || pop)) begin
        rec.e = m_cap;
        rec.l = pio_rd;
        m_q.push_back(rec);
      end
      m_ovf <= (push && full && !pop) || (m_ovf && !overflow_clr);
      if (cap_valid) m_cap <= pio_rd;
    end
  end

  int mw0;

  initial begin
    enable       = 1'b1;
    mask_load    = 1'b0;
    mask_value   = '0;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;

    // Reset state and the MASK_INIT write.
    tick(2);
    check_bus("rst", 1'b0, 1'b1, 2'd0, 32'h0);
    check("rst_addr", pio_address, 2'd0);
    check("rst_wdata", pio_writedata, 32'h0);
    check("rst_busy", busy, 1'b1);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    reset_n = 1'b1;
    tick(1);
    check_bus("init_wr", 1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF);
    check("init_busy", busy, 1'b1);
    tick(1);
    check_bus("init_idle", 1'b0, 1'b1, 2'd0, 32'h0);
    check("init_idle_busy", busy, 1'b0);
    check("init_mask", pio_mask, 32'hFFFF_FFFF);

    // Bit 5 falls; level afterwards is 1.
    in_port = 32'h21;
    tick(2);
    in_port = 32'h01;
    tick(2);
    check_bus("svc_rdcap", 1'b1, 1'b1, 2'd3, 32'h0);
    tick(1);
    check_bus("svc_clr", 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
    tick(1);
    check_bus("svc_rdlvl", 1'b1, 1'b1, 2'd0, 32'h0);
    check("svc_ec_cleared", pio_ec, 32'h0);
    tick(1);
    check("svc_lvldata_cs", pio_chipselect, 1'b0);
    check("svc_not_yet", evt_valid, 1'b0);
    tick(1);
    check("svc_valid", evt_valid, 1'b1);
    check("svc_edges", evt_edges, 32'h20);
    check("svc_level", evt_level, 32'h1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("svc_popped", fifo_count, 3'd0);

    // irq ignored while disabled.
    enable    = 1'b0;
    irq_force = 1'b1;
    tick(3);
    check("dis_busy", busy, 1'b0);
    irq_force = 1'b0;
    enable    = 1'b1;
    tick(1);

    // Spurious irq: full sequence, nothing queued.
    irq_force = 1'b1;
    tick(1);
    check_bus("spur_rdcap", 1'b1, 1'b1, 2'd3, 32'h0);
    irq_force = 1'b0;
    tick(1);
    check_bus("spur_clr", 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
    tick(3);
    check("spur_busy", busy, 1'b0);
    check("spur_count", fifo_count, 3'd0);
    check("spur_ovf", overflow, 1'b0);

    // Five events with no consumer: fifth is dropped.
    in_port = 32'h1F;
    tick(2);
    for (int k = 0; k < 5; k++) begin
      in_port = in_port & ~(32'h1 << k);
      tick(7);
    end
    check("ovf_count", fifo_count, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", evt_edges, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", evt_edges, 32'h1 << i);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
    end
    check("ovf_drained", fifo_count, 3'd0);
    check("ovf_sticky", overflow, 1'b1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Full FIFO with a pop in the LVL_DATA cycle accepts the push.
    in_port = 32'h1F;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      in_port = in_port & ~(32'h1 << k);
      tick(7);
    end
    check("full_count", fifo_count, 3'd4);
    in_port = 32'h0;
    tick(5);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("full_pp_count", fifo_count, 3'd4);
    check("full_pp_ovf", overflow, 1'b0);
    check("full_pp_head", evt_edges, 32'h2);
    evt_ready = 1'b1;
    tick(4);
    evt_ready = 1'b0;
    check("full_drained", fifo_count, 3'd0);

    // mask_load during RD_LVL: WR_MASK precedes the pending irq.
    in_port = 32'h3;
    tick(2);
    in_port = 32'h2;
    tick(4);
    check_bus("ml_rdlvl", 1'b1, 1'b1, 2'd0, 32'h0);
    in_port    = 32'h0;
    mask_load  = 1'b1;
    mask_value = 32'hF;
    tick(1);
    mask_load = 1'b0;
    tick(2);
    check_bus("ml_wrmask", 1'b1, 1'b0, 2'd2, 32'hF);
    tick(2);
    check_bus("ml_then_rdcap", 1'b1, 1'b1, 2'd3, 32'h0);
    tick(5);
    check("ml_count", fifo_count, 3'd2);
    evt_ready = 1'b1;
    tick(2);
    evt_ready = 1'b0;

    // Two mask_loads while busy collapse into one write of the latest value.
    mw0     = mask_writes;
    in_port = 32'h4;
    tick(2);
    in_port = 32'h0;
    tick(2);
    mask_load  = 1'b1;
    mask_value = 32'h1;
    tick(1);
    mask_value = 32'h3;
    tick(1);
    mask_load = 1'b0;
    tick(3);
    check_bus("ml2_wrmask", 1'b1, 1'b0, 2'd2, 32'h3);
    tick(2);
    check("ml2_idle_cs", pio_chipselect, 1'b0);
    check("ml2_one_write", 32'(mask_writes), 32'(mw0 + 1));
    check("ml2_mask", pio_mask, 32'h3);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("end_count", fifo_count, 3'd0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_event_sequencer.md
Name: pio_event_sequencer

Overview:
- Avalon-MM master that services one 32-bit edge-capture PIO slave: programs its irq mask, reacts to its irq, reads and clears the edge-capture register, and samples the input level.
- Each serviced interrupt becomes one event record {edges, level} in a small FIFO with a valid/ready consumer interface.
- Sits between the PIO slave and on-chip logic that needs edge events without CPU involvement.

Parameters:
- WIDTH, 32, PIO data width (edge/level/mask width).
- FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2.
- MASK_INIT, {WIDTH{1'b1}}, irq_mask value written after every reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = service pio_irq; 0 = ignore irq (mask writes still performed).
- mask_load  in  1  single-cycle request to write mask_value to PIO irq_mask.
- mask_value  in  WIDTH  mask sampled when mask_load=1.
- pio_address  out  2  PIO register select (0 data, 2 irq_mask, 3 edge_capture).
- pio_chipselect  out  1  PIO chipselect.
- pio_write_n  out  1  PIO write strobe, active-low.
- pio_writedata  out  WIDTH  PIO write data.
- pio_readdata  in  WIDTH  PIO read data; registered, valid the cycle after the address phase.
- pio_irq  in  1  PIO interrupt, level.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts head entry.
- evt_edges  out  WIDTH  head entry captured edges.
- evt_level  out  WIDTH  head entry sampled input level.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky: an event was dropped.
- overflow_clr  in  1  clears overflow.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0, FIFO empty (evt_valid 0, fifo_count 0), overflow 0, busy 1. Mask pending flag cleared. First state after reset is WR_MASK with MASK_INIT.
- Asserting reset mid-operation aborts any transaction and flushes the FIFO. The MASK_INIT write is repeated after reset; any previously loaded mask is lost.
- All pio_* outputs are registered and reflect the current state: they change only on the clock edge that enters the state.
- WR_MASK: cs=1, write_n=0, addr=2, wdata=mask. Lasts 1 cycle, then IDLE.
- IDLE: cs=0, write_n=1. Priority order:
  - mask pending -> WR_MASK;
  - else enable&pio_irq -> RD_CAP;
  - else stay.
- RD_CAP: cs=1, write_n=1, addr=3. Lasts 1 cycle, then CLR.
- CLR: cs=1, write_n=0, addr=3, wdata=all ones. pio_readdata latched into edge_reg at the end of this cycle. Then RD_LVL.
- RD_LVL: cs=1, write_n=1, addr=0. Lasts 1 cycle, then LVL_DATA.
- LVL_DATA: cs=0. pio_readdata is the level. At the end of the cycle, push {edge_reg, level} if edge_reg != 0, then go to IDLE.
  - edge_reg == 0 (spurious or already cleared): no push, no overflow.
- Latency: if IDLE samples pio_irq=1 at edge e0 and the FIFO is empty, evt_valid=1 after e4. Minimum service period is 5 cycles, so irq still high on return to IDLE restarts at the next edge.
- Known, accepted limitation: an edge captured by the PIO on the edges ending RD_CAP or CLR is cleared without being reported.
- mask_load may arrive in any state. It latches mask_value and sets pending; the latest value wins. Pending clears on entering WR_MASK. A mask_load in the same cycle as WR_MASK re-arms pending with the new value.
- FIFO:
  - Push accepted if not full, or if full and a pop occurs the same cycle.
  - Otherwise the event is dropped and overflow is set.
  - Pop on evt_valid&evt_ready. evt_edges/evt_level present the head entry (first-word fall-through). Pointers wrap modulo FIFO_DEPTH.
- overflow_clr and an overflow set in the same cycle leave overflow=1.
- enable deassertion mid-sequence does not abort the sequence; it takes effect in IDLE.

Test Plan:
- Reset release -> next cycle: cs=1, write_n=0, addr=2, wdata=32'hFFFFFFFF for exactly 1 cycle, then idle bus; evt_valid=0.
- PIO model in_port bit5 falls with in_port=32'h00000001 after the fall -> bus sequence RD_CAP/CLR/RD_LVL, then evt_edges=32'h20, evt_level=32'h1, evt_valid high 4 edges after irq sampled; model edge_capture=0 afterwards.
- irq forced high with edge_capture=0 at read -> full bus sequence runs, no push, fifo_count stays 0, overflow stays 0.
- evt_ready=0 with 5 distinct events (bits 0..4) -> fifo_count=4, overflow=1, head evt_edges=32'h1; pop all -> order 1,2,4,8; overflow_clr -> overflow=0.
- FIFO full and evt_ready=1 in the LVL_DATA cycle -> push accepted, fifo_count stays 4, overflow=0.
- mask_load with 32'h0000000F during RD_LVL -> sequence completes, then WR_MASK writes 32'hF before servicing a pending irq; two mask_loads (0x1, then 0x3) while busy -> single write of 32'h3.
